// File: rtl/char_frame_counter.sv
// char_frame_counter: oversampled serial character frame counter.
// Follows start / data / (parity) / stop bit timing on a pre-synchronised
// serial line, emits a one-cycle strobe at the middle of every data bit,
// a one-cycle end-of-frame pulse, and sticky framing / parity error flags.
// Optional feature macro: PARITY_EN adds a parity bit between data and stop.
// fsm_state exposes the controller state for observation.
module char_frame_counter #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          bitStream,
    output logic                          SRclk,
    output logic                          charReceived,
    output logic [3:0]                    BIC,
    output logic [$clog2(OVERSAMPLE)-1:0] BSC,
    output logic                          frameErr,
    output logic                          parErr,
    output logic                          busy,
    output logic [2:0]                    fsm_state
);

    localparam int BW = $clog2(OVERSAMPLE);

    // Start bit is checked at its middle; data/parity/stop at the last sample
    // of each bit period, which lands half a bit after the bit boundary.
    localparam logic [BW-1:0] BSC_HALF = BW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BSC_LAST = BW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BSC_ONE  = BW'(1);
    localparam logic [3:0]    BIC_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    BIC_ONE  = 4'd1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t state;

`ifdef PARITY_EN
    logic par_acc;
    logic par_err_q;
`endif

    // Frame controller: state, counters, strobes and error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            BIC          <= '0;
            BSC          <= '0;
            SRclk        <= 1'b0;
            charReceived <= 1'b0;
            frameErr     <= 1'b0;
`ifdef PARITY_EN
            par_acc      <= 1'b0;
            par_err_q    <= 1'b0;
`endif
        end else if (!enable) begin
            // Everything holds; strobes are suppressed on a frozen cycle.
            SRclk        <= 1'b0;
            charReceived <= 1'b0;
        end else begin
            SRclk        <= 1'b0;
            charReceived <= 1'b0;
            case (state)
                S_IDLE: begin
                    BSC <= '0;
                    BIC <= '0;
                    if (!bitStream) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (BSC == BSC_HALF) begin
                        BSC <= '0;
                        if (!bitStream) begin
                            // Genuine start bit: a new frame begins, old flags clear.
                            state    <= S_DATA;
                            BIC      <= '0;
                            frameErr <= 1'b0;
`ifdef PARITY_EN
                            par_acc   <= 1'b0;
                            par_err_q <= 1'b0;
`endif
                        end else begin
                            // Line went back high: treat as noise, keep flags.
                            state <= S_IDLE;
                        end
                    end else begin
                        BSC <= BSC + BSC_ONE;
                    end
                end
                S_DATA: begin
                    // Power-of-two oversampling lets BSC wrap on its own.
                    BSC <= BSC + BSC_ONE;
                    if (BSC == BSC_LAST) begin
                        SRclk <= 1'b1;
                        BIC   <= BIC + BIC_ONE;
`ifdef PARITY_EN
                        par_acc <= par_acc ^ bitStream;
`endif
                        if (BIC == BIC_LAST) begin
`ifdef PARITY_EN
                            state <= S_PARITY;
`else
                            state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    BSC <= BSC + BSC_ONE;
                    if (BSC == BSC_LAST) begin
                        par_err_q <= par_acc ^ bitStream ^ PARITY_ODD;
                        state     <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    BSC <= BSC + BSC_ONE;
                    if (BSC == BSC_LAST) begin
                        charReceived <= 1'b1;
                        frameErr     <= ~bitStream;
                        BIC          <= '0;
                        state        <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    BSC   <= '0;
                    BIC   <= '0;
                end
            endcase
        end
    end

`ifdef PARITY_EN
    assign parErr = par_err_q;
`else
    // No parity bit in the frame: the flag is constant low and the parity
    // sense parameter has no effect.
    assign parErr = PARITY_ODD & 1'b0;
`endif

    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

endmodule
